trilat_sched: RTL and testbench

- Sequencer that shares one single-vertex trilateration datapath (instance of one_vertex) across every anchor triplet drawn from a small anchor bank.
- Anchors (x, y, r) are loaded through a config write port.
- On start, the block issues all C(M,3) triplets in fixed order, waits for the datapath, and accumulates the returned xT/yT.
- It reports signed sums and the triplet count; averaging is done downstream.

---
 rtl/trilat_sched.sv | 205 ++++++++++++++++++++
 tb/tb_trilat_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trilat_sched.sv
// trilat_sched: walks every anchor triplet (i<j<k) of a small anchor bank
// through one shared single-vertex trilateration datapath and accumulates
// the returned xT/yT into signed running sums plus a triplet count.
module trilat_sched #(
   parameter int N   = 8,
   parameter int M   = 4,
   parameter int AW  = 2,
   parameter int LAT = 1,
   parameter int SW  = 14
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_we,
   input  logic [AW-1:0]        cfg_addr,
   input  logic [N-1:0]         cfg_x,
   input  logic [N-1:0]         cfg_y,
   input  logic [N:0]           cfg_r,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [N-1:0]         ov_xU,
   output logic [N-1:0]         ov_yU,
   output logic [N-1:0]         ov_xV,
   output logic [N-1:0]         ov_yV,
   output logic [N-1:0]         ov_xW,
   output logic [N-1:0]         ov_yW,
   output logic [N:0]           ov_rU,
   output logic [N:0]           ov_rV,
   output logic [N:0]           ov_rW,
   input  logic signed [N+1:0]  ov_xT,
   input  logic signed [N+1:0]  ov_yT,
   output logic signed [SW-1:0] sum_x,
   output logic signed [SW-1:0] sum_y,
   output logic [7:0]           count,
   output logic                 result_valid
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_ACC,
      S_DONE
   } state_t;

   // Wait counter is loaded with LAT-1, so it needs to hold at least that value.
   localparam int WCW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [WCW-1:0] WAIT_INIT = WCW'(LAT - 1);

   // Index values of the final triplet (M-3, M-2, M-1).
   localparam logic [AW-1:0] I_LAST = AW'(M - 3);
   localparam logic [AW-1:0] J_LAST = AW'(M - 2);
   localparam logic [AW-1:0] K_LAST = AW'(M - 1);

   // One extra bit so an address equal to 2^AW-range limits compares correctly.
   localparam logic [AW:0] M_LIM = (AW + 1)'(M);

   state_t state, next_state;

   logic [N-1:0] bank_x [M];
   logic [N-1:0] bank_y [M];
   logic [N:0]   bank_r [M];

   logic [AW-1:0]  idx_i, idx_j, idx_k;
   logic [WCW-1:0] wait_cnt;

   logic addr_ok;
   logic last_trip;
   logic start_ok;

   assign addr_ok   = ({1'b0, cfg_addr} < M_LIM);
   assign last_trip = (idx_i == I_LAST) && (idx_j == J_LAST) && (idx_k == K_LAST);
   assign start_ok  = (state == S_IDLE) && start;

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

   // State register; reset can abort a run from any state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: ISSUE and ACC are single cycles, WAIT lasts LAT cycles.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (start) next_state = S_ISSUE;
         S_ISSUE: next_state = S_WAIT;
         S_WAIT:  if (wait_cnt == '0) next_state = S_ACC;
         S_ACC:   next_state = last_trip ? S_DONE : S_ISSUE;
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Anchor bank: writable only while idle, so a run always sees a stable bank.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int a = 0; a < M; a++) begin
            bank_x[a] <= '0;
            bank_y[a] <= '0;
            bank_r[a] <= '0;
         end
      end else if ((state == S_IDLE) && cfg_we && addr_ok) begin
         bank_x[cfg_addr] <= cfg_x;
         bank_y[cfg_addr] <= cfg_y;
         bank_r[cfg_addr] <= cfg_r;
      end
   end

   // Triplet walker and wait counter: lexicographic i<j<k, reset to (0,1,2) on start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_i    <= '0;
         idx_j    <= AW'(1);
         idx_k    <= AW'(2);
         wait_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  idx_i <= '0;
                  idx_j <= AW'(1);
                  idx_k <= AW'(2);
               end
            end
            S_ISSUE: begin
               wait_cnt <= WAIT_INIT;
            end
            S_WAIT: begin
               if (wait_cnt != '0) begin
                  wait_cnt <= wait_cnt - WCW'(1);
               end
            end
            S_ACC: begin
               if (!last_trip) begin
                  if (idx_k != K_LAST) begin
                     idx_k <= idx_k + AW'(1);
                  end else if (idx_j != J_LAST) begin
                     idx_j <= idx_j + AW'(1);
                     idx_k <= idx_j + AW'(2);
                  end else begin
                     idx_i <= idx_i + AW'(1);
                     idx_j <= idx_i + AW'(2);
                     idx_k <= idx_i + AW'(3);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Operand registers: captured at the end of ISSUE and held through ACC and after the run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ov_xU <= '0;
         ov_yU <= '0;
         ov_xV <= '0;
         ov_yV <= '0;
         ov_xW <= '0;
         ov_yW <= '0;
         ov_rU <= '0;
         ov_rV <= '0;
         ov_rW <= '0;
      end else if (state == S_ISSUE) begin
         ov_xU <= bank_x[idx_i];
         ov_yU <= bank_y[idx_i];
         ov_rU <= bank_r[idx_i];
         ov_xV <= bank_x[idx_j];
         ov_yV <= bank_y[idx_j];
         ov_rV <= bank_r[idx_j];
         ov_xW <= bank_x[idx_k];
         ov_yW <= bank_y[idx_k];
         ov_rW <= bank_r[idx_k];
      end
   end

   // Accumulators: cleared on an accepted start, sign-extended add in ACC, wrap on overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_x        <= '0;
         sum_y        <= '0;
         count        <= '0;
         result_valid <= 1'b0;
      end else if (start_ok) begin
         sum_x        <= '0;
         sum_y        <= '0;
         count        <= '0;
         result_valid <= 1'b0;
      end else if (state == S_ACC) begin
         sum_x <= sum_x + SW'(ov_xT);
         sum_y <= sum_y + SW'(ov_yT);
         count <= count + 8'd1;
         if (last_trip) begin
            result_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_trilat_sched.sv
// Bench for trilat_sched: two instances (LAT=1 and LAT=3) share stimulus and
// each is fed by a combinational stub datapath. Operand triplets are checked
// against a queue of expected values pushed when a run is started.
module tb_trilat_sched;

   localparam int N  = 8;
   localparam int M  = 4;
   localparam int AW = 2;
   localparam int SW = 14;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cfg_we = 1'b0;
   logic [AW-1:0] cfg_addr = '0;
   logic [N-1:0] cfg_x = '0;
   logic [N-1:0] cfg_y = '0;
   logic [N:0] cfg_r = '0;
   logic start = 1'b0;

   // LAT=1 instance signals
   logic busy1, done1, rv1;
   logic [N-1:0] xu1, yu1, xv1, yv1, xw1, yw1;
   logic [N:0] ru1, rv_1, rw1;
   logic signed [N+1:0] xt1, yt1;
   logic signed [SW-1:0] sx1, sy1;
   logic [7:0] cnt1;

   // LAT=3 instance signals
   logic busy3, done3, rv3;
   logic [N-1:0] xu3, yu3, xv3, yv3, xw3, yw3;
   logic [N:0] ru3, rv_3, rw3;
   logic signed [N+1:0] xt3, yt3;
   logic signed [SW-1:0] sx3, sy3;
   logic [7:0] cnt3;

   int mode = 0;
   int n_checks = 0;
   int n_fails = 0;

   int ax [M];
   int ay [M];
   int ar [M];

   logic [74:0] exp_q [$];

   typedef struct {
      int mode;
      bit disturb;
      bit wr0;
      int exp_sx;
      int exp_sy;
      int exp_cnt;
   } vec_t;

   always #5 clk = ~clk;

   // Stub datapath: constant (5,-3) in mode 0, (xU, yW) sign-extended in mode 1.
   assign xt1 = (mode == 0) ? 10'sd5  : {{2{xu1[N-1]}}, xu1};
   assign yt1 = (mode == 0) ? -10'sd3 : {{2{yw1[N-1]}}, yw1};
   assign xt3 = (mode == 0) ? 10'sd5  : {{2{xu3[N-1]}}, xu3};
   assign yt3 = (mode == 0) ? -10'sd3 : {{2{yw3[N-1]}}, yw3};

   trilat_sched #(.N(N), .M(M), .AW(AW), .LAT(1), .SW(SW)) dut1 (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_r(cfg_r), .start(start),
      .busy(busy1), .done(done1),
      .ov_xU(xu1), .ov_yU(yu1), .ov_xV(xv1), .ov_yV(yv1), .ov_xW(xw1), .ov_yW(yw1),
      .ov_rU(ru1), .ov_rV(rv_1), .ov_rW(rw1),
      .ov_xT(xt1), .ov_yT(yt1),
      .sum_x(sx1), .sum_y(sy1), .count(cnt1), .result_valid(rv1)
   );

   trilat_sched #(.N(N), .M(M), .AW(AW), .LAT(3), .SW(SW)) dut3 (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_r(cfg_r), .start(start),
      .busy(busy3), .done(done3),
      .ov_xU(xu3), .ov_yU(yu3), .ov_xV(xv3), .ov_yV(yv3), .ov_xW(xw3), .ov_yW(yw3),
      .ov_rU(ru3), .ov_rV(rv_3), .ov_rW(rw3),
      .ov_xT(xt3), .ov_yT(yt3),
      .sum_x(sx3), .sum_y(sy3), .count(cnt3), .result_valid(rv3)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkVec(input string name, input logic [74:0] actual, input logic [74:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   function automatic logic [74:0] packTrip(input int i, input int j, input int k);
      return {8'(ax[i]), 8'(ay[i]), 8'(ax[j]), 8'(ay[j]), 8'(ax[k]), 8'(ay[k]),
              9'(ar[i]), 9'(ar[j]), 9'(ar[k])};
   endfunction

   function automatic logic [74:0] ov1();
      return {xu1, yu1, xv1, yv1, xw1, yw1, ru1, rv_1, rw1};
   endfunction

   function automatic logic [74:0] ov3();
      return {xu3, yu3, xv3, yv3, xw3, yw3, ru3, rv_3, rw3};
   endfunction

   // Write the whole bench anchor model into both instances, one entry per cycle.
   task automatic loadAnchors();
      for (int a = 0; a < M; a++) begin
         @(negedge clk);
         cfg_we   = 1'b1;
         cfg_addr = AW'(a);
         cfg_x    = 8'(ax[a]);
         cfg_y    = 8'(ay[a]);
         cfg_r    = 9'(ar[a]);
      end
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // Run one pass on both instances and check operands, timing and sums.
   task automatic applyStimulus(input vec_t v);
      int e;
      int d1;
      int d3;
      e  = 0;
      d1 = -1;
      d3 = -1;
      mode = v.mode;
      exp_q.delete();
      @(negedge clk);
      if (v.wr0) begin
         ax[0] = 7;
         ay[0] = -20;
         ar[0] = 30;
         cfg_we   = 1'b1;
         cfg_addr = '0;
         cfg_x    = 8'(ax[0]);
         cfg_y    = 8'(ay[0]);
         cfg_r    = 9'(ar[0]);
      end
      start = 1'b1;
      for (int i = 0; i < M; i++)
         for (int j = i + 1; j < M; j++)
            for (int k = j + 1; k < M; k++)
               exp_q.push_back(packTrip(i, j, k));
      @(negedge clk);
      start  = 1'b0;
      cfg_we = 1'b0;
      while ((d1 < 0 || d3 < 0) && e < 40) begin
         @(negedge clk);
         e++;
         if (e == 1) begin
            checkOutput("cleared_count", int'(cnt1), 0);
            checkOutput("cleared_valid", int'(rv1), 0);
            checkOutput("busy_after_start", int'(busy1), 1);
         end
         if (e >= 1 && e <= 12) begin
            if (exp_q.size() == 0) begin
               checkOutput("operand_queue_empty", 0, 1);
            end else begin
               checkVec("operands_lat1", ov1(), exp_q[0]);
               if ((e - 1) % 3 == 2) void'(exp_q.pop_front());
            end
         end
         if (e == 1 && v.wr0) begin
            checkOutput("new_anchor0_lat3", int'($signed(xu3)), 7);
         end
         if (done1 && d1 < 0) d1 = e;
         if (done3 && d3 < 0) d3 = e;
         if (v.disturb && e == 3) begin
            start    = 1'b1;
            cfg_we   = 1'b1;
            cfg_addr = '0;
            cfg_x    = 8'd1;
            cfg_y    = 8'd1;
            cfg_r    = 9'd1;
         end else begin
            start  = 1'b0;
            cfg_we = 1'b0;
         end
      end
      checkOutput("done_edge_lat1", d1, 12);
      checkOutput("done_edge_lat3", d3, 20);
      checkOutput("sum_x_lat1", int'(sx1), v.exp_sx);
      checkOutput("sum_y_lat1", int'(sy1), v.exp_sy);
      checkOutput("count_lat1", int'(cnt1), v.exp_cnt);
      checkOutput("valid_lat1", int'(rv1), 1);
      checkOutput("busy_end_lat1", int'(busy1), 0);
      checkOutput("sum_x_lat3", int'(sx3), v.exp_sx);
      checkOutput("sum_y_lat3", int'(sy3), v.exp_sy);
      checkOutput("count_lat3", int'(cnt3), v.exp_cnt);
      checkOutput("valid_lat3", int'(rv3), 1);
      checkVec("operands_hold_last", ov1(), packTrip(1, 2, 3));
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      vec_t vecs [5];
      vecs[0] = '{mode: 0, disturb: 1'b0, wr0: 1'b0, exp_sx: 20,  exp_sy: -12, exp_cnt: 4};
      vecs[1] = '{mode: 1, disturb: 1'b0, wr0: 1'b0, exp_sx: 61,  exp_sy: 258, exp_cnt: 4};
      vecs[2] = '{mode: 1, disturb: 1'b1, wr0: 1'b0, exp_sx: 61,  exp_sy: 258, exp_cnt: 4};
      vecs[3] = '{mode: 1, disturb: 1'b0, wr0: 1'b1, exp_sx: 130, exp_sy: 258, exp_cnt: 4};
      vecs[4] = '{mode: 0, disturb: 1'b0, wr0: 1'b0, exp_sx: 20,  exp_sy: -12, exp_cnt: 4};

      ax = '{-16, 109, -32, 50};
      ay = '{-111, -99, 108, 50};
      ar = '{236, 183, 215, 100};

      // Reset state.
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", int'(busy1), 0);
      checkOutput("reset_done", int'(done1), 0);
      checkOutput("reset_sum_x", int'(sx1), 0);
      checkOutput("reset_valid", int'(rv1), 0);
      checkVec("reset_operands", ov1(), '0);
      rst = 1'b0;

      // Reset mid-run, in the WAIT of the second triplet.
      loadAnchors();
      mode = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("pre_reset_sum_x", int'(sx1), 5);
      rst = 1'b1;
      #1;
      checkOutput("midrst_busy1", int'(busy1), 0);
      checkOutput("midrst_busy3", int'(busy3), 0);
      checkOutput("midrst_sum_x", int'(sx1), 0);
      checkOutput("midrst_sum_y", int'(sy1), 0);
      checkOutput("midrst_count", int'(cnt1), 0);
      checkVec("midrst_operands1", ov1(), '0);
      checkVec("midrst_operands3", ov3(), '0);
      @(negedge clk);
      rst = 1'b0;
      loadAnchors();

      for (int t = 0; t < 5; t++) begin
         $display("[TB] vector %0d: mode=%0d disturb=%0d wr0=%0d", t, vecs[t].mode,
                  vecs[t].disturb, vecs[t].wr0);
         applyStimulus(vecs[t]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
